// File: rtl/ula_pkg.sv
// Shared definitions for the ALU / multiply-divide block: opcodes, FSM states, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ula_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MFHI  = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/ula_iter_core.sv
// Iterative magnitude multiply (shift-add) / restoring divide with sign fix-up on the outputs.
// Latency: WIDTH cycles after i_start; o_done flags the last step, o_hi/o_lo are valid the cycle after.
// Backpressure: none; the owning FSM starts it only when idle and samples the result once.
module ula_iter_core
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int              CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [WIDTH:0]     r_acc;      // partial product high half, or partial remainder
    logic [WIDTH-1:0]   r_q;        // multiplier shifting out / dividend shifting into quotient
    logic [WIDTH-1:0]   r_m;        // |multiplicand| or |divisor|
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_neg_q;    // negate product / quotient
    logic               r_neg_r;    // negate remainder (dividend was negative)

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_shrem;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_a_neg = i_signed & i_a[WIDTH-1];
    assign w_b_neg = i_signed & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // Multiply step: conditionally add the multiplicand before the joint right shift.
    assign w_madd  = r_q[0] ? (r_acc + {1'b0, r_m}) : r_acc;

    // Divide step: the borrow bit of the trial subtraction decides restore vs keep.
    assign w_shrem = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial = w_shrem - {1'b0, r_m};

    assign w_prod     = {r_acc[WIDTH-1:0], r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    assign o_done = (r_cnt == CNT_ONE);

    // Sign fix-up is combinational off the finished magnitudes; consumed in FIX.
    always_comb begin
        if (r_div) begin
            o_lo = r_neg_q ? -r_q : r_q;
            o_hi = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end else begin
            o_lo = w_prod_fix[WIDTH-1:0];
            o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // Operand capture on start, then one product/quotient bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_acc   <= '0;
            r_q     <= w_a_mag;
            r_m     <= w_b_mag;
            r_cnt   <= CNT_LOAD;
            r_div   <= i_div;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_div) begin
                if (!w_trial[WIDTH]) begin
                    r_acc <= w_trial;
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= w_shrem;
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc <= {1'b0, w_madd[WIDTH:1]};
                r_q   <= {w_madd[0], r_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/ula_mdu.sv
// EX-stage ALU with registered results plus iterative MULT/DIV and architectural HI/LO.
// Latency: result in the cycle after acceptance for single-cycle ops; WIDTH+1 edges after acceptance for MUL/DIV.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no input buffering.
module ula_mdu
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MSB = WIDTH - 1;

    state_t           r_state;
    logic             r_in_rdy;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_signed;
    logic             w_start;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_alu_known;
    logic             w_core_done;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;

    assign in_ready  = r_in_rdy;
    assign out_valid = r_out_vld;
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign div_zero  = r_dz;
    assign hi        = r_hi;
    assign lo        = r_lo;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_b_zero = (b == '0);
    assign w_start  = w_accept && (w_is_mul || (w_is_div && !w_b_zero));
    assign w_sum    = a + b;
    assign w_diff   = a - b;

    // Single-cycle result; unknown opcodes report 0 with every flag (zero included) cleared.
    always_comb begin
        w_alu_res   = '0;
        w_alu_ovf   = 1'b0;
        w_alu_known = 1'b1;
        case (op)
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_NOR:  w_alu_res = ~(a | b);
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: w_alu_res = r_hi;
            OP_MFLO: w_alu_res = r_lo;
            default: w_alu_known = 1'b0;
        endcase
    end

    ula_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_div    (w_is_div),
        .i_signed (w_signed),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_core_done),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    // Control FSM with registered handshake outputs, result, flags and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_rdy <= 1'b0;
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else if (w_is_div && !w_b_zero) begin
                            r_state <= ST_DIV;
                        end else if (w_is_div) begin
                            r_hi      <= a;
                            r_lo      <= '1;
                            r_result  <= '1;
                            r_zero    <= 1'b0;
                            r_ovf     <= 1'b0;
                            r_dz      <= 1'b1;
                            r_out_vld <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_result  <= w_alu_res;
                            r_zero    <= w_alu_known && (w_alu_res == '0);
                            r_ovf     <= w_alu_ovf;
                            r_dz      <= 1'b0;
                            r_out_vld <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_core_done) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi      <= w_core_hi;
                    r_lo      <= w_core_lo;
                    r_result  <= w_core_lo;
                    r_zero    <= (w_core_lo == '0);
                    r_ovf     <= 1'b0;
                    r_dz      <= 1'b0;
                    r_out_vld <= 1'b1;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_in_rdy  <= 1'b1;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_mdu.sv
// Scoreboard bench for ula_mdu: expectations computed from a wide-integer model at issue time.
// Latency: checked in clock edges counted from the accepting edge.
// Backpressure: out_ready held low for a programmable number of cycles per result.
module tb_ula_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    ula_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] res;
        logic         z;
        logic         v;
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           t0 = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model on 64-bit integers; updates the HI/LO model as the DUT should.
    task automatic predict(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output exp_t e);
        longint sx, sy, ux, uy, q, r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        e.op  = o;
        e.res = '0;
        e.v   = 1'b0;
        e.dz  = 1'b0;
        e.lat = 0;  // single-cycle result visible right after the accepting edge
        case (o)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b1100: e.res = ~(x | y);
            4'b0010: begin
                e.res = x + y;
                e.v   = (sx + sy) != longint'($signed(e.res));
            end
            4'b0110: begin
                e.res = x - y;
                e.v   = (sx - sy) != longint'($signed(e.res));
            end
            4'b0111: e.res = {{(W-1){1'b0}}, (sx < sy)};
            4'b0101: e.res = {{(W-1){1'b0}}, (ux < uy)};
            4'b0011: e.res = m_hi;
            4'b0100: e.res = m_lo;
            4'b1000, 4'b1001: begin
                p = (o == 4'b1000) ? sx * sy : ux * uy;
                m_hi  = p[63:32];
                m_lo  = p[31:0];
                e.res = m_lo;
                e.lat = W + 1;
            end
            4'b1010, 4'b1011: begin
                if (y == '0) begin
                    m_hi  = x;
                    m_lo  = '1;
                    e.res = '1;
                    e.dz  = 1'b1;
                end else begin
                    if (o == 4'b1010) begin
                        q = sx / sy;
                        r = sx % sy;
                    end else begin
                        q = ux / uy;
                        r = ux % uy;
                    end
                    m_lo  = W'(q);
                    m_hi  = W'(r);
                    e.res = m_lo;
                    e.lat = W + 1;
                end
            end
            default: e.res = '0;
        endcase
        e.z  = (e.res == '0);
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   k;
        predict(o, x, y, e);
        sb.push_back(e);
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check_val("in_ready_timeout", 64'd0, 64'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        in_valid = 1'b0;
        // Scramble inputs: the DUT must work from what it captured.
        op = 4'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   k;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            check_val($sformatf("out_valid_timeout op%0h", e.op), 64'd0, 64'd1);
            return;
        end
        check_val($sformatf("latency op%0h", e.op), 64'(cyc - t0), 64'(e.lat));
        check_val($sformatf("result op%0h", e.op), result, e.res);
        check_val($sformatf("zero op%0h", e.op), zero, e.z);
        check_val($sformatf("ovf op%0h", e.op), ovf, e.v);
        check_val($sformatf("div_zero op%0h", e.op), div_zero, e.dz);
        check_val($sformatf("hi op%0h", e.op), hi, e.hi);
        check_val($sformatf("lo op%0h", e.op), lo, e.lo);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val($sformatf("hold_valid c%0d", i), out_valid, 1'b1);
            check_val($sformatf("hold_in_ready c%0d", i), in_ready, 1'b0);
            check_val($sformatf("hold_result c%0d", i), result, e.res);
            check_val($sformatf("hold_ovf c%0d", i), ovf, e.v);
            check_val($sformatf("hold_zero c%0d", i), zero, e.z);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val($sformatf("in_ready_after_take op%0h", e.op), in_ready, 1'b1);
        check_val($sformatf("valid_after_take op%0h", e.op), out_valid, 1'b0);
    endtask

    task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold);
        issue(o, x, y);
        collect(hold);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [13];
        exp_t       dropped;
        int         seen;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b1100,
                4'b0011, 4'b0100, 4'b1000, 4'b1001, 4'b1010, 4'b1011};

        repeat (3) @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_zero", zero, 1'b0);
        check_val("rst_ovf", ovf, 1'b0);
        check_val("rst_div_zero", div_zero, 1'b0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        run(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);  // ADD overflow
        run(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0);  // SLT
        run(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 0);  // SLTU
        run(4'b1100, 32'h0F0F_0000, 32'h00F0_000F, 0);  // NOR
        run(4'b1000, 32'hFFFF_FFFD, 32'h0000_0005, 0);  // MULT -3*5
        run(4'b0011, 32'h0, 32'h0, 0);                  // MFHI
        run(4'b1001, 32'hFFFF_FFFF, 32'h0000_0002, 0);  // MULTU
        run(4'b1010, 32'hFFFF_FFF9, 32'h0000_0002, 0);  // DIV -7/2
        run(4'b0100, 32'h0, 32'h0, 0);                  // MFLO
        run(4'b1011, 32'h0000_0007, 32'h0000_0000, 0);  // DIVU by zero
        run(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 0);  // most-negative / -1
        run(4'b1010, 32'h0000_0007, 32'hFFFF_FFFE, 0);  // DIV 7/-2
        run(4'b0110, 32'h8000_0000, 32'h0000_0001, 3);  // SUB overflow under back-pressure
        run(4'b0110, 32'h1234_5678, 32'h1234_5678, 0);  // SUB to zero
        run(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run(4'b0001, 32'hF000_0001, 32'h0000_1000, 2);

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = (i % 4 == 0) ? W'($urandom_range(0, 3)) : $urandom;
            run(ops[$urandom_range(0, 12)], x, y, $urandom_range(0, 2));
        end

        // Abort a divide mid-flight; no result may appear and HI/LO must clear.
        issue(4'b1010, 32'h0001_0000, 32'h0000_0007);
        dropped = sb.pop_back();
        while (cyc < t0 + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", in_ready, 1'b1);
        check_val("abort_out_valid", out_valid, 1'b0);
        check_val("abort_hi", hi, 32'd0);
        check_val("abort_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val($sformatf("abort_no_result op%0h", dropped.op), 64'(seen), 64'd0);
        run(4'b0010, 32'h0000_0005, 32'h0000_0006, 0);
        run(4'b0011, 32'h0, 32'h0, 0);  // HI cleared by reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
